// File: rtl/iq_pkg.sv
// Shared types and helpers for the out-of-order issue queue.
package iq_pkg;

    localparam int unsigned IQ_TAG_W     = 7;
    localparam int unsigned IQ_ROB_W     = 8;
    localparam int unsigned IQ_PAYLOAD_W = 128;
    // Widest vector popcount() accepts; callers zero-extend narrower vectors.
    localparam int unsigned IQ_POP_W     = 64;

    typedef struct packed {
        logic                    valid;
        logic                    rdy1;
        logic                    rdy2;
        logic [IQ_TAG_W-1:0]     src1_tag;
        logic [IQ_TAG_W-1:0]     src2_tag;
        logic [IQ_TAG_W-1:0]     dest;
        logic [IQ_ROB_W-1:0]     rob_idx;
        logic [IQ_PAYLOAD_W-1:0] payload;
    } iq_entry_t;

    function automatic logic [6:0] popcount(input logic [IQ_POP_W-1:0] vec);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < IQ_POP_W; i++) begin
            cnt = cnt + 7'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/iq_age_select.sv
// Age matrix plus oldest-first selection of up to ISSUE_W ready entries.
// r_older[i][j] = 1 means entry j is older than entry i.
module iq_age_select
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ISSUE_W = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_flush,
    input  logic                            i_stall,
    input  logic [DEPTH-1:0]                i_valid,
    input  logic [DEPTH-1:0]                i_ready,
    input  logic [DEPTH-1:0]                i_alloc,
    output logic [ISSUE_W-1:0][DEPTH-1:0]   o_grant,
    output logic [DEPTH-1:0]                o_issue
);

    logic [DEPTH-1:0][DEPTH-1:0] r_older;
    logic [DEPTH-1:0][DEPTH-1:0] w_older_d;
    logic [DEPTH-1:0][6:0]       w_rank;
    logic [DEPTH-1:0]            w_valid_kept;

    // Rank of each entry = number of older entries that are also ready
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_rank[i] = popcount(IQ_POP_W'(i_ready & r_older[i]));
        end
    end

    // Ready entry with rank r drives lane r; ranks of ready entries are unique
    always_comb begin
        o_grant = '0;
        for (int l = 0; l < ISSUE_W; l++) begin
            for (int i = 0; i < DEPTH; i++) begin
                o_grant[l][i] = i_ready[i] && !i_stall && (w_rank[i] == 7'(l));
            end
        end
    end

    // Union of all lane grants: entries freed at the coming edge
    always_comb begin
        o_issue = '0;
        for (int l = 0; l < ISSUE_W; l++) begin
            o_issue = o_issue | o_grant[l];
        end
    end

    // New rows see survivors plus lower-index same-cycle allocations;
    // new columns are cleared so a reused slot is younger than everyone.
    always_comb begin
        logic [DEPTH-1:0] lower;
        w_valid_kept = i_valid & ~o_issue;
        for (int i = 0; i < DEPTH; i++) begin
            lower = (DEPTH'(1) << i) - DEPTH'(1);
            if (i_alloc[i]) begin
                w_older_d[i] = w_valid_kept | (i_alloc & lower);
            end else begin
                w_older_d[i] = r_older[i] & ~i_alloc;
            end
        end
    end

    // Age matrix storage
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_older <= '0;
        end else begin
            r_older <= w_older_d;
        end
    end

endmodule

// File: rtl/issue_queue_ooo.sv
// Out-of-order issue queue: dispatch, wakeup capture, oldest-first issue.
// TAG_W/ROB_W/PAYLOAD_W must match the iq_pkg entry field widths.
module issue_queue_ooo
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DISPATCH_W = 8,
    parameter int unsigned ISSUE_W    = 2,
    parameter int unsigned WAKE_W     = 4,
    parameter int unsigned TAG_W      = IQ_TAG_W,
    parameter int unsigned ROB_W      = IQ_ROB_W,
    parameter int unsigned PAYLOAD_W  = IQ_PAYLOAD_W,
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DISPATCH_W-1:0]                alloc_valid_i,
    output logic                                 dispatch_ready_o,
    input  logic [DISPATCH_W-1:0][TAG_W-1:0]     src1_tag_i,
    input  logic [DISPATCH_W-1:0][TAG_W-1:0]     src2_tag_i,
    input  logic [DISPATCH_W-1:0]                rdy1_i,
    input  logic [DISPATCH_W-1:0]                rdy2_i,
    input  logic [DISPATCH_W-1:0][TAG_W-1:0]     dest_tag_i,
    input  logic [DISPATCH_W-1:0][ROB_W-1:0]     rob_idx_i,
    input  logic [DISPATCH_W-1:0][PAYLOAD_W-1:0] payload_i,
    input  logic [WAKE_W-1:0]                    wake_valid_i,
    input  logic [WAKE_W-1:0][TAG_W-1:0]         wake_tag_i,
    input  logic                                 issue_stall_i,
    input  logic                                 flush_i,
    output logic [ISSUE_W-1:0]                   issue_valid_o,
    output logic [ISSUE_W-1:0][TAG_W-1:0]        issue_dest_o,
    output logic [ISSUE_W-1:0][ROB_W-1:0]        issue_rob_idx_o,
    output logic [ISSUE_W-1:0][PAYLOAD_W-1:0]    issue_payload_o,
    output logic [CNT_W-1:0]                     count_o
);

    localparam int unsigned LANE_W = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;

    iq_entry_t                         r_entry   [DEPTH];
    iq_entry_t                         w_entry_d [DEPTH];
    logic [CNT_W-1:0]                  r_count;
    logic [CNT_W-1:0]                  w_count_d;
    logic [DEPTH-1:0]                  w_valid;
    logic [DEPTH-1:0]                  w_ready;
    logic                              w_accept;
    logic [DEPTH-1:0]                  w_alloc;
    logic [DEPTH-1:0][LANE_W-1:0]      w_alloc_lane;
    logic [ISSUE_W-1:0][DEPTH-1:0]     w_grant;
    logic [DEPTH-1:0]                  w_issue;
    logic [ISSUE_W-1:0][TAG_W-1:0]     w_sel_dest;
    logic [ISSUE_W-1:0][ROB_W-1:0]     w_sel_rob;
    logic [ISSUE_W-1:0][PAYLOAD_W-1:0] w_sel_payload;

    logic [ISSUE_W-1:0]                r_issue_valid;
    logic [ISSUE_W-1:0][TAG_W-1:0]     r_issue_dest;
    logic [ISSUE_W-1:0][ROB_W-1:0]     r_issue_rob;
    logic [ISSUE_W-1:0][PAYLOAD_W-1:0] r_issue_payload;

    function automatic logic wake_hit(input logic [WAKE_W-1:0]            vld,
                                      input logic [WAKE_W-1:0][TAG_W-1:0] tags,
                                      input logic [TAG_W-1:0]             tag);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WAKE_W; w++) begin
            hit = hit | (vld[w] && (tags[w] == tag));
        end
        return hit;
    endfunction

    assign dispatch_ready_o = (CNT_W'(DEPTH) - r_count) >= CNT_W'(DISPATCH_W);
    assign w_accept         = dispatch_ready_o && !flush_i;

    // Per-entry valid and ready vectors for selection
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = r_entry[i].valid;
            w_ready[i] = r_entry[i].valid && r_entry[i].rdy1 && r_entry[i].rdy2;
        end
    end

    iq_age_select #(
        .DEPTH   (DEPTH),
        .ISSUE_W (ISSUE_W)
    ) u_age_select (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush_i),
        .i_stall (issue_stall_i),
        .i_valid (w_valid),
        .i_ready (w_ready),
        .i_alloc (w_alloc),
        .o_grant (w_grant),
        .o_issue (w_issue)
    );

    // Accepted lanes take the lowest free slots in lane order; issuing slots count as free
    always_comb begin
        logic [DEPTH-1:0] free_v;
        logic             found;
        free_v       = ~w_valid | w_issue;
        w_alloc      = '0;
        w_alloc_lane = '0;
        for (int d = 0; d < DISPATCH_W; d++) begin
            found = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_accept && alloc_valid_i[d] && !found && free_v[i]) begin
                    w_alloc[i]      = 1'b1;
                    w_alloc_lane[i] = LANE_W'(d);
                    free_v[i]       = 1'b0;
                    found           = 1'b1;
                end
            end
        end
    end

    // Entry next state: wakeup capture, issue free, allocation, flush
    always_comb begin
        logic [LANE_W-1:0] lane;
        for (int i = 0; i < DEPTH; i++) begin
            lane         = w_alloc_lane[i];
            w_entry_d[i] = r_entry[i];
            if (r_entry[i].valid) begin
                w_entry_d[i].rdy1 = r_entry[i].rdy1 |
                                    wake_hit(wake_valid_i, wake_tag_i, r_entry[i].src1_tag);
                w_entry_d[i].rdy2 = r_entry[i].rdy2 |
                                    wake_hit(wake_valid_i, wake_tag_i, r_entry[i].src2_tag);
            end
            if (w_issue[i]) begin
                w_entry_d[i].valid = 1'b0;
            end
            if (w_alloc[i]) begin
                w_entry_d[i].valid    = 1'b1;
                // Same-cycle broadcast is folded in so a wakeup is never lost
                w_entry_d[i].rdy1     = rdy1_i[lane] |
                                        wake_hit(wake_valid_i, wake_tag_i, src1_tag_i[lane]);
                w_entry_d[i].rdy2     = rdy2_i[lane] |
                                        wake_hit(wake_valid_i, wake_tag_i, src2_tag_i[lane]);
                w_entry_d[i].src1_tag = src1_tag_i[lane];
                w_entry_d[i].src2_tag = src2_tag_i[lane];
                w_entry_d[i].dest     = dest_tag_i[lane];
                w_entry_d[i].rob_idx  = rob_idx_i[lane];
                w_entry_d[i].payload  = payload_i[lane];
            end
            if (flush_i) begin
                w_entry_d[i].valid = 1'b0;
            end
        end
    end

    // Lane data mux from the one-hot grants
    always_comb begin
        w_sel_dest    = '0;
        w_sel_rob     = '0;
        w_sel_payload = '0;
        for (int l = 0; l < ISSUE_W; l++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_grant[l][i]) begin
                    w_sel_dest[l]    = r_entry[i].dest;
                    w_sel_rob[l]     = r_entry[i].rob_idx;
                    w_sel_payload[l] = r_entry[i].payload;
                end
            end
        end
    end

    // Occupancy: minus issued, plus accepted; flush empties the queue
    always_comb begin
        if (flush_i) begin
            w_count_d = '0;
        end else begin
            w_count_d = r_count - CNT_W'(popcount(IQ_POP_W'(w_issue)));
            if (w_accept) begin
                w_count_d = w_count_d + CNT_W'(popcount(IQ_POP_W'(alloc_valid_i)));
            end
        end
    end

    // Entry array and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_entry_d[i];
            end
            r_count <= w_count_d;
        end
    end

    // Registered issue lanes; idle lanes hold their data fields
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_valid   <= '0;
            r_issue_dest    <= '0;
            r_issue_rob     <= '0;
            r_issue_payload <= '0;
        end else begin
            for (int l = 0; l < ISSUE_W; l++) begin
                r_issue_valid[l] <= !flush_i && (|w_grant[l]);
                if (!flush_i && (|w_grant[l])) begin
                    r_issue_dest[l]    <= w_sel_dest[l];
                    r_issue_rob[l]     <= w_sel_rob[l];
                    r_issue_payload[l] <= w_sel_payload[l];
                end
            end
        end
    end

    assign issue_valid_o   = r_issue_valid;
    assign issue_dest_o    = r_issue_dest;
    assign issue_rob_idx_o = r_issue_rob;
    assign issue_payload_o = r_issue_payload;
    assign count_o         = r_count;

endmodule

// File: tb/tb_issue_queue_ooo.sv
// Scoreboard bench for issue_queue_ooo: stimulus pushes expected issues,
// a negedge monitor pops and compares whenever a lane is valid.
module tb_issue_queue_ooo;

    localparam int DEPTH      = 16;
    localparam int DISPATCH_W = 8;
    localparam int ISSUE_W    = 2;
    localparam int WAKE_W     = 4;
    localparam int TAG_W      = 7;
    localparam int ROB_W      = 8;
    localparam int PAYLOAD_W  = 128;
    localparam int CNT_W      = $clog2(DEPTH) + 1;

    logic                                 clk;
    logic                                 rst;
    logic [DISPATCH_W-1:0]                alloc_valid_i;
    logic                                 dispatch_ready_o;
    logic [DISPATCH_W-1:0][TAG_W-1:0]     src1_tag_i;
    logic [DISPATCH_W-1:0][TAG_W-1:0]     src2_tag_i;
    logic [DISPATCH_W-1:0]                rdy1_i;
    logic [DISPATCH_W-1:0]                rdy2_i;
    logic [DISPATCH_W-1:0][TAG_W-1:0]     dest_tag_i;
    logic [DISPATCH_W-1:0][ROB_W-1:0]     rob_idx_i;
    logic [DISPATCH_W-1:0][PAYLOAD_W-1:0] payload_i;
    logic [WAKE_W-1:0]                    wake_valid_i;
    logic [WAKE_W-1:0][TAG_W-1:0]         wake_tag_i;
    logic                                 issue_stall_i;
    logic                                 flush_i;
    logic [ISSUE_W-1:0]                   issue_valid_o;
    logic [ISSUE_W-1:0][TAG_W-1:0]        issue_dest_o;
    logic [ISSUE_W-1:0][ROB_W-1:0]        issue_rob_idx_o;
    logic [ISSUE_W-1:0][PAYLOAD_W-1:0]    issue_payload_o;
    logic [CNT_W-1:0]                     count_o;

    typedef struct {
        int cyc;
        int lane;
        int dest;
        int rob;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t;

    issue_queue_ooo #(
        .DEPTH      (DEPTH),
        .DISPATCH_W (DISPATCH_W),
        .ISSUE_W    (ISSUE_W),
        .WAKE_W     (WAKE_W),
        .TAG_W      (TAG_W),
        .ROB_W      (ROB_W),
        .PAYLOAD_W  (PAYLOAD_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_valid_i    (alloc_valid_i),
        .dispatch_ready_o (dispatch_ready_o),
        .src1_tag_i       (src1_tag_i),
        .src2_tag_i       (src2_tag_i),
        .rdy1_i           (rdy1_i),
        .rdy2_i           (rdy2_i),
        .dest_tag_i       (dest_tag_i),
        .rob_idx_i        (rob_idx_i),
        .payload_i        (payload_i),
        .wake_valid_i     (wake_valid_i),
        .wake_tag_i       (wake_tag_i),
        .issue_stall_i    (issue_stall_i),
        .flush_i          (flush_i),
        .issue_valid_o    (issue_valid_o),
        .issue_dest_o     (issue_dest_o),
        .issue_rob_idx_o  (issue_rob_idx_o),
        .issue_payload_o  (issue_payload_o),
        .count_o          (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PAYLOAD_W-1:0] mk_payload(input int dst, input int rob);
        return {8{8'(rob), 1'b0, 7'(dst)}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        alloc_valid_i = '0;
        src1_tag_i    = '0;
        src2_tag_i    = '0;
        rdy1_i        = '0;
        rdy2_i        = '0;
        dest_tag_i    = '0;
        rob_idx_i     = '0;
        payload_i     = '0;
        wake_valid_i  = '0;
        wake_tag_i    = '0;
        issue_stall_i = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic put(input int d, input int s1, input int r1, input int s2, input int r2,
                       input int dst, input int rob);
        alloc_valid_i[d] = 1'b1;
        src1_tag_i[d]    = 7'(s1);
        rdy1_i[d]        = 1'(r1);
        src2_tag_i[d]    = 7'(s2);
        rdy2_i[d]        = 1'(r2);
        dest_tag_i[d]    = 7'(dst);
        rob_idx_i[d]     = 8'(rob);
        payload_i[d]     = mk_payload(dst, rob);
    endtask

    task automatic wake(input int p, input int tag);
        wake_valid_i[p] = 1'b1;
        wake_tag_i[p]   = 7'(tag);
    endtask

    task automatic push(input int c, input int lane, input int dst, input int rob);
        exp_t e;
        e.cyc  = c;
        e.lane = lane;
        e.dest = dst;
        e.rob  = rob;
        sb.push_back(e);
    endtask

    // Monitor: flag overdue expectations, then match every valid lane in order
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_issue: got nothing expected dest %0d rob %0d lane %0d at cycle %0d",
                         sb[0].dest, sb[0].rob, sb[0].lane, sb[0].cyc);
                void'(sb.pop_front());
            end
            for (int l = 0; l < ISSUE_W; l++) begin
                if (issue_valid_o[l]) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_issue: got lane %0d dest %0d rob %0d at cycle %0d expected none",
                                 l, issue_dest_o[l], issue_rob_idx_o[l], cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.cyc != cyc || mon_e.lane != l ||
                            int'(issue_dest_o[l]) != mon_e.dest ||
                            int'(issue_rob_idx_o[l]) != mon_e.rob ||
                            issue_payload_o[l] !== mk_payload(mon_e.dest, mon_e.rob)) begin
                            n_fail++;
                            $display("FAIL issue_match: got cyc %0d lane %0d dest %0d rob %0d payload %0h expected cyc %0d lane %0d dest %0d rob %0d",
                                     cyc, l, issue_dest_o[l], issue_rob_idx_o[l], issue_payload_o[l],
                                     mon_e.cyc, mon_e.lane, mon_e.dest, mon_e.rob);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear_in();
        step();
        step();
        check("rst_issue_valid", 128'(issue_valid_o), 128'(0));
        check("rst_count", 128'(count_o), 128'(0));
        check("rst_dest", 128'(issue_dest_o), 128'(0));
        check("rst_payload", 128'(issue_payload_o[0]), 128'(0));
        rst = 1'b0;
        step();
        check("rdy_empty", 128'(dispatch_ready_o), 128'(1));

        // Single ready dispatch on lane 0
        t = cyc;
        put(0, 0, 1, 0, 1, 5, 3);
        push(t + 2, 0, 5, 3);
        step();
        clear_in();
        check("single_count1", 128'(count_o), 128'(1));
        step();
        check("single_count0", 128'(count_o), 128'(0));
        step();
        step();

        // A waits on tag 9, B ready one cycle later issues first
        t = cyc;
        put(0, 9, 0, 0, 1, 20, 10);
        step();
        put(0, 0, 1, 0, 1, 21, 11);
        push(t + 3, 0, 21, 11);
        step();
        clear_in();
        wake(1, 8);
        wake_tag_i[3] = 7'd9;
        step();
        clear_in();
        wake(2, 9);
        push(t + 5, 0, 20, 10);
        step();
        clear_in();
        step();
        step();
        step();

        // Sparse group of three ready entries, two issue lanes
        t = cyc;
        put(0, 0, 1, 0, 1, 30, 40);
        put(3, 0, 1, 0, 1, 31, 41);
        put(6, 0, 1, 0, 1, 32, 42);
        push(t + 2, 0, 30, 40);
        push(t + 2, 1, 31, 41);
        push(t + 3, 0, 32, 42);
        step();
        clear_in();
        check("group_count3", 128'(count_o), 128'(3));
        step();
        check("group_count1", 128'(count_o), 128'(1));
        step();
        check("group_count0", 128'(count_o), 128'(0));
        step();

        // Same-cycle wake of a dispatching source
        t = cyc;
        put(2, 0, 1, 12, 0, 50, 60);
        wake(1, 12);
        push(t + 2, 0, 50, 60);
        step();
        clear_in();
        step();
        step();
        step();

        // Stall with ready entries, then flush (dispatch in flush cycle dropped)
        put(0, 0, 1, 0, 1, 70, 80);
        put(1, 0, 1, 0, 1, 71, 81);
        issue_stall_i = 1'b1;
        step();
        clear_in();
        issue_stall_i = 1'b1;
        check("stall_count", 128'(count_o), 128'(2));
        step();
        issue_stall_i = 1'b1;
        check("stall_valid_a", 128'(issue_valid_o), 128'(0));
        step();
        issue_stall_i = 1'b1;
        check("stall_valid_b", 128'(issue_valid_o), 128'(0));
        step();
        check("stall_valid_c", 128'(issue_valid_o), 128'(0));
        check("stall_count_held", 128'(count_o), 128'(2));
        clear_in();
        flush_i = 1'b1;
        put(0, 0, 1, 0, 1, 99, 99);
        step();
        clear_in();
        check("flush_count", 128'(count_o), 128'(0));
        check("flush_valid", 128'(issue_valid_o), 128'(0));
        step();
        step();
        check("flush_count_stays", 128'(count_o), 128'(0));
        step();
        step();

        // Fill past the dispatch threshold, then drain one entry at a time
        t = cyc;
        for (int d = 0; d < DISPATCH_W; d++) begin
            put(d, 100, 0, 0, 1, 120 + d, 130 + d);
        end
        step();
        clear_in();
        check("fill_count8", 128'(count_o), 128'(8));
        check("fill_rdy8", 128'(dispatch_ready_o), 128'(1));
        put(0, 101, 0, 0, 1, 90, 150);
        put(1, 102, 0, 0, 1, 91, 151);
        step();
        clear_in();
        check("fill_count10", 128'(count_o), 128'(10));
        check("fill_rdy10", 128'(dispatch_ready_o), 128'(0));
        for (int d = 0; d < DISPATCH_W; d++) begin
            put(d, 0, 1, 0, 1, 10 + d, 10 + d);
        end
        step();
        clear_in();
        check("fill_ignored_count", 128'(count_o), 128'(10));
        check("fill_ignored_rdy", 128'(dispatch_ready_o), 128'(0));
        wake(0, 101);
        push(t + 5, 0, 90, 150);
        step();
        clear_in();
        step();
        check("drain_count9", 128'(count_o), 128'(9));
        check("drain_rdy9", 128'(dispatch_ready_o), 128'(0));
        wake(3, 102);
        push(t + 7, 0, 91, 151);
        step();
        clear_in();
        step();
        check("drain_count8", 128'(count_o), 128'(8));
        check("drain_rdy8", 128'(dispatch_ready_o), 128'(1));
        wake(0, 100);
        wake(1, 100);
        for (int k = 0; k < 4; k++) begin
            push(t + 9 + k, 0, 120 + 2 * k, 130 + 2 * k);
            push(t + 9 + k, 1, 121 + 2 * k, 131 + 2 * k);
        end
        step();
        clear_in();
        step();
        check("burst_count6", 128'(count_o), 128'(6));
        step();
        step();
        step();
        check("burst_count0", 128'(count_o), 128'(0));
        step();

        // Reset mid-stream dominates a pending issue
        put(0, 0, 1, 0, 1, 100, 200);
        put(1, 0, 1, 0, 1, 101, 201);
        step();
        clear_in();
        rst = 1'b1;
        step();
        check("mid_rst_valid", 128'(issue_valid_o), 128'(0));
        check("mid_rst_count", 128'(count_o), 128'(0));
        check("mid_rst_dest", 128'(issue_dest_o), 128'(0));
        check("mid_rst_rob", 128'(issue_rob_idx_o), 128'(0));
        check("mid_rst_payload", 128'(issue_payload_o[1]), 128'(0));
        rst = 1'b0;
        step();
        step();
        step();
        check("post_rst_count", 128'(count_o), 128'(0));
        check("post_rst_rdy", 128'(dispatch_ready_o), 128'(1));

        check("sb_drained", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue_ooo.md
Name: issue_queue_ooo

Overview:
Parametrised successor to the 8-wide in-order issue queue. Holds up to DEPTH dispatched micro-ops with two source tags each, and captures ready bits from WAKE_W result-tag broadcast ports. Every cycle it issues up to ISSUE_W ready entries, oldest first and out of program order, into registered issue lanes. Sits between rename/dispatch and the execution ports. Adds global stall and flush.

Parameters:
DEPTH, 16, entry count (power of two, ≥ DISPATCH_W)
DISPATCH_W, 8, dispatch lanes per cycle
ISSUE_W, 2, issue lanes per cycle
WAKE_W, 4, wakeup broadcast ports
TAG_W, 7, physical register tag width
ROB_W, 8, ROB index width
PAYLOAD_W, 128, opaque payload (operands/opcode) carried to issue

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_valid_i  in  DISPATCH_W  per-lane dispatch request (sparse allowed)
dispatch_ready_o  out  1  queue can accept a full DISPATCH_W group this cycle
src1_tag_i/src2_tag_i  in  [DISPATCH_W][TAG_W]  source tags
rdy1_i/rdy2_i  in  DISPATCH_W  source already ready at dispatch
dest_tag_i  in  [DISPATCH_W][TAG_W]  destination tag
rob_idx_i  in  [DISPATCH_W][ROB_W]  ROB index
payload_i  in  [DISPATCH_W][PAYLOAD_W]  payload
wake_valid_i  in  WAKE_W  broadcast valid
wake_tag_i  in  [WAKE_W][TAG_W]  broadcast tag
issue_stall_i  in  1  suppress selection this cycle
flush_i  in  1  discard all entries
issue_valid_o  out  ISSUE_W  issue lane valid (registered)
issue_dest_o  out  [ISSUE_W][TAG_W]  issued dest tag
issue_rob_idx_o  out  [ISSUE_W][ROB_W]  issued ROB index
issue_payload_o  out  [ISSUE_W][PAYLOAD_W]  issued payload
count_o  out  $clog2(DEPTH)+1  occupied entries (registered)

Behaviour:
- Reset (sync, rst=1 at posedge): all entry valid=0, age matrix=0, count_o=0, issue_valid_o=0. Dest/rob/payload outputs go to 0. Reset dominates flush, dispatch, wakeup and issue.
- dispatch_ready_o = (DEPTH − count_o) ≥ DISPATCH_W; combinational from registered count. Requests while it is 0 are ignored. No partial acceptance.
- Allocation: accepted valid lanes fill the lowest-index free entries, in lane order. Among entries written in the same cycle, a lower lane is older.
- Age matrix: older[i][j]=1 means entry j is older than i. A new entry's row = valid vector after this cycle's issue frees, plus lower same-cycle lanes. Its column is 0.
- Wakeup: at each posedge, every valid entry's rdyN is set if srcN_tag matches any valid wake tag. A dispatching lane's rdyN = rdyN_i OR a same-cycle wake match (no lost wakeup).
- Selection (combinational, current state): ready = valid & rdy1 & rdy2. rank(i) = popcount(ready & older[i]). Entry i goes to lane rank(i) if rank < ISSUE_W and issue_stall_i=0.
- Issue: at the posedge, lane outputs are registered and selected entries are invalidated (freed). Unused lanes get valid=0 and hold their data fields. Latency: a wake at edge E makes the entry selectable in cycle E+1, and issue_valid_o rises at edge E+2. Dispatch with both sources ready behaves the same (issue_valid_o at edge dispatch+2).
- Freed entries may be reallocated in the same cycle.
- count_o next = count − issued + accepted; never exceeds DEPTH, never underflows.
- issue_stall_i=1: no selection, issue_valid_o=0 next cycle; dispatch and wakeup continue.
- flush_i=1: next edge clears all valid bits, issue_valid_o=0, count_o=0. Dispatch in a flush cycle is dropped. Wakeups are irrelevant.
- Tag 0 gets no special treatment; duplicate wake tags are harmless.

Decomposition:
- Shared package iq_pkg: iq_entry_t (valid, rdy1, rdy2, src tags, dest, rob_idx, payload) parameterised via localparams, and a popcount function.
- One sub-module: iq_age_select (age matrix storage, rank computation, one-hot lane grants).

Test Plan:
- Reset then single dispatch, lane0, rdy1=rdy2=1, dest=5, rob=3 → issue_valid_o=01 at dispatch edge+2, dest 5, rob 3; count_o returns 0.
- Dispatch A (src1 tag 9 not ready), then B (ready) next cycle; wake tag 9 two cycles later → B issues first, A issues on lane0 two edges after wake.
- Three ready entries dispatched in one group, ISSUE_W=2 → lanes 0/1 = lanes 0/1 of the group, third entry issues next cycle on lane0.
- Dispatch with src2 tag 12 not ready while wake_tag 12 is valid in the same cycle → entry issues at edge+2, no hang.
- Fill to DEPTH−DISPATCH_W+1 entries → dispatch_ready_o=0, further requests ignored, count_o unchanged; one issue does not reopen it until count ≤ DEPTH−DISPATCH_W.
- Hold issue_stall_i 3 cycles with ready entries → issue_valid_o=0 throughout. Then flush_i → count_o=0 and no issue afterwards. Reset asserted mid-stream → all outputs 0 next edge.
